// File: rtl/gpu_pkg.sv
// gpu_pkg: shared arbiter state encoding and tile-count default
package gpu_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA} arb_state_t;
  localparam int GPU_N_TILES = 4;
endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: combinational round-robin pick of the first requester after last_grant
module rr_priority_picker
  import gpu_pkg::*;
#(
  parameter int N_REQ = GPU_N_TILES,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic             any,
  output logic [IDX_W-1:0] winner
);
  logic [IDX_W-1:0] idx;
  // scan offsets from farthest to nearest so the nearest requester after last_grant wins
  always_comb begin
    any = |req;
    winner = '0;
    idx = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = IDX_W'((int'(last_grant) + k) % N_REQ);
      if (req[idx]) winner = idx;
    end
  end
endmodule

// File: rtl/gpu_bus_arbiter.sv
// gpu_bus_arbiter: round-robin sharing of one Avalon-MM master among tile controllers, plus irq aggregation
module gpu_bus_arbiter
  import gpu_pkg::*;
#(
  parameter int N_REQ  = GPU_N_TILES,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int IDX_W  = $clog2(N_REQ)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [N_REQ-1:0][ADDR_W-1:0]  req_address,
  input  logic [N_REQ-1:0][DATA_W-1:0]  req_writedata,
  input  logic [N_REQ-1:0]              req_read,
  input  logic [N_REQ-1:0]              req_write,
  output logic [N_REQ-1:0]              req_waitrequest,
  output logic [DATA_W-1:0]             req_readdata,
  output logic [N_REQ-1:0]              req_readdatavalid,
  input  logic [N_REQ-1:0]              req_irq,
  output logic [N_REQ-1:0]              req_clear_interrupt,
  output logic [ADDR_W-1:0]             m1_address,
  output logic [DATA_W-1:0]             m1_writedata,
  output logic                          m1_read,
  output logic                          m1_write,
  input  logic                          m1_waitrequest,
  input  logic                          m1_readdatavalid,
  input  logic [DATA_W-1:0]             m1_readdata,
  input  logic                          clear_interrupt,
  output logic                          irq
);
  arb_state_t state, state_n;
  logic [IDX_W-1:0] grant, last_grant, winner;
  logic any, wr, rd, done;
  logic [N_REQ-1:0] grant_oh;

  rr_priority_picker #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_picker (
    .req       (req_read | req_write),
    .last_grant(last_grant),
    .any       (any),
    .winner    (winner)
  );

  assign req_readdata = m1_readdata;
  assign req_clear_interrupt = {N_REQ{clear_interrupt}};
  assign grant_oh = N_REQ'(1) << grant;

  // next state, master strobes and per-requester completion; write wins when both strobes are set
  always_comb begin
    wr = req_write[grant];
    rd = req_read[grant] & ~wr;
    state_n = state;
    done = 1'b0;
    m1_read = 1'b0;
    m1_write = 1'b0;
    m1_address = '0;
    m1_writedata = '0;
    unique case (state)
      IDLE: state_n = any ? ISSUE : IDLE;
      ISSUE: begin
        m1_write = wr;
        m1_read = rd;
        m1_address = req_address[grant];
        m1_writedata = req_writedata[grant];
        if (!wr && !rd) state_n = IDLE;
        else if (!m1_waitrequest) begin
          done = wr | m1_readdatavalid;
          state_n = done ? IDLE : WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        done = m1_readdatavalid;
        state_n = m1_readdatavalid ? IDLE : WAIT_DATA;
      end
      default: state_n = IDLE;
    endcase
    req_waitrequest = done ? ~grant_oh : '1;
    req_readdatavalid = (done && !(state == ISSUE && wr)) ? grant_oh : '0;
  end

  // state register; grant and last_grant latch the winner on leaving IDLE
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      last_grant <= IDX_W'(N_REQ - 1);
    end else begin
      state <= state_n;
      if (state == IDLE && any) begin
        grant <= winner;
        last_grant <= winner;
      end
    end
  end

  // frame done once every tile reports done, registered
  always_ff @(posedge clock or posedge reset) begin
    if (reset) irq <= 1'b0;
    else irq <= &req_irq;
  end
endmodule

// File: tb/tb_gpu_bus_arbiter.sv
// tb_gpu_bus_arbiter: directed stimulus with a transaction-level reference model checked every cycle
module tb_gpu_bus_arbiter;
  logic clock, reset;
  logic [3:0][31:0] req_address, req_writedata;
  logic [3:0] req_read, req_write, req_waitrequest, req_readdatavalid, req_irq, req_clear_interrupt;
  logic [31:0] req_readdata, m1_address, m1_writedata, m1_readdata;
  logic m1_read, m1_write, m1_waitrequest, m1_readdatavalid, clear_interrupt, irq;
  int n_chk = 0, n_fail = 0;

  gpu_bus_arbiter dut (
    .clock(clock), .reset(reset),
    .req_address(req_address), .req_writedata(req_writedata),
    .req_read(req_read), .req_write(req_write),
    .req_waitrequest(req_waitrequest), .req_readdata(req_readdata),
    .req_readdatavalid(req_readdatavalid), .req_irq(req_irq),
    .req_clear_interrupt(req_clear_interrupt),
    .m1_address(m1_address), .m1_writedata(m1_writedata),
    .m1_read(m1_read), .m1_write(m1_write),
    .m1_waitrequest(m1_waitrequest), .m1_readdatavalid(m1_readdatavalid),
    .m1_readdata(m1_readdata), .clear_interrupt(clear_interrupt), .irq(irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: owner of the bus (-1 when free), whether its read has been accepted, last winner
  int own, last, n_own, n_last, oi, j;
  bit acc, n_acc, irq_m, live, fin;
  logic e_m1w, e_m1r;
  logic [31:0] e_addr, e_wd;
  logic [3:0] e_wait, e_rdv;

  always_comb begin
    oi = (own < 0) ? 0 : own;
    live = (own >= 0) && !acc;
    e_m1w = live && req_write[oi];
    e_m1r = live && req_read[oi] && !req_write[oi];
    e_addr = live ? req_address[oi] : 32'h0;
    e_wd = live ? req_writedata[oi] : 32'h0;
    fin = (own >= 0) && ((live && !m1_waitrequest && (e_m1w || (e_m1r && m1_readdatavalid))) || (acc && m1_readdatavalid));
    e_wait = fin ? ~(4'b1 << oi) : 4'hF;
    e_rdv = (fin && !e_m1w) ? (4'b1 << oi) : 4'h0;
    n_own = own;
    n_acc = acc;
    n_last = last;
    j = 0;
    if (own < 0) begin
      for (int k = 1; k <= 4; k++) begin
        j = (last + k) % 4;
        if (n_own < 0 && (req_read[j] || req_write[j])) begin
          n_own = j;
          n_last = j;
        end
      end
    end else if (fin || (live && !e_m1w && !e_m1r)) begin
      n_own = -1;
      n_acc = 1'b0;
    end else if (live && !m1_waitrequest) n_acc = 1'b1;
  end

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      own <= -1;
      acc <= 1'b0;
      last <= 3;
      irq_m <= 1'b0;
    end else begin
      own <= n_own;
      acc <= n_acc;
      last <= n_last;
      irq_m <= &req_irq;
    end
  end

  bit rr_on = 1'b0;
  int order[$];

  always @(negedge clock) begin
    chk("m1_write", m1_write, e_m1w);
    chk("m1_read", m1_read, e_m1r);
    chk("m1_address", m1_address, e_addr);
    chk("m1_writedata", m1_writedata, e_wd);
    chk("req_waitrequest", req_waitrequest, e_wait);
    chk("req_readdatavalid", req_readdatavalid, e_rdv);
    chk("req_readdata", req_readdata, m1_readdata);
    chk("irq", irq, irq_m);
    chk("req_clear_interrupt", req_clear_interrupt, {4{clear_interrupt}});
    if (rr_on && m1_write && !m1_waitrequest) order.push_back(int'(m1_address[3:0]));
  end

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    reset = 1'b1;
    req_address = '0; req_writedata = '0; req_read = '0; req_write = '0; req_irq = '0;
    m1_waitrequest = 1'b0; m1_readdatavalid = 1'b0; m1_readdata = 32'h1234; clear_interrupt = 1'b0;
    step; step;
    chk("reset waitreq", req_waitrequest, 4'hF);
    chk("reset irq", irq, 1'b0);
    chk("reset m1_write", m1_write, 1'b0);
    chk("reset m1_address", m1_address, 32'h0);
    reset = 1'b0;
    step;
    // single write from tile 2
    req_address[2] = 32'h100; req_writedata[2] = 32'hAB; req_write[2] = 1'b1;
    #1 chk("wr idle", m1_write, 1'b0);
    step;
    #1 chk("wr strobe", m1_write, 1'b1);
    chk("wr addr", m1_address, 32'h100);
    chk("wr data", m1_writedata, 32'hAB);
    chk("wr waitreq", req_waitrequest, 4'b1011);
    step;
    req_write[2] = 1'b0;
    #1 chk("wr after", m1_write, 1'b0);
    chk("wr after waitreq", req_waitrequest, 4'hF);
    step;
    // read from tile 1, data three cycles after acceptance
    req_address[1] = 32'h200; req_read[1] = 1'b1;
    step;
    #1 chk("rd strobe", m1_read, 1'b1);
    chk("rd addr", m1_address, 32'h200);
    chk("rd issue waitreq", req_waitrequest, 4'hF);
    step;
    #1 chk("rd wait strobe", m1_read, 1'b0);
    chk("rd wait rdv", req_readdatavalid, 4'h0);
    step; step;
    m1_readdatavalid = 1'b1; m1_readdata = 32'h55;
    #1 chk("rd rdv", req_readdatavalid, 4'b0010);
    chk("rd waitreq", req_waitrequest, 4'b1101);
    chk("rd data", req_readdata, 32'h55);
    step;
    req_read[1] = 1'b0; m1_readdatavalid = 1'b0;
    #1 chk("rd after rdv", req_readdatavalid, 4'h0);
    step;
    // both strobes: treated as a write
    req_address[2] = 32'h180; req_read[2] = 1'b1; req_write[2] = 1'b1;
    step;
    #1 chk("both write", m1_write, 1'b1);
    chk("both read", m1_read, 1'b0);
    step;
    req_read[2] = 1'b0; req_write[2] = 1'b0;
    step;
    // abandon: tile 1 wins then drops; last_grant stays 1 so tile 2 beats tile 0
    req_write[1] = 1'b1;
    step;
    req_write[1] = 1'b0;
    #1 chk("abandon strobe", m1_write, 1'b0);
    chk("abandon waitreq", req_waitrequest, 4'hF);
    req_address[0] = 32'h400; req_address[2] = 32'h402; req_write[0] = 1'b1; req_write[2] = 1'b1;
    step; step;
    #1 chk("after abandon winner", m1_address, 32'h402);
    step;
    req_write[0] = 1'b0; req_write[2] = 1'b0;
    step;
    // stalled slave for 5 cycles
    m1_waitrequest = 1'b1; req_address[3] = 32'h300; req_write[3] = 1'b1;
    step;
    for (int i = 0; i < 5; i++) begin
      #1 chk("stall strobe", m1_write, 1'b1);
      chk("stall addr", m1_address, 32'h300);
      chk("stall waitreq", req_waitrequest, 4'hF);
      step;
    end
    m1_waitrequest = 1'b0;
    #1 chk("stall release waitreq", req_waitrequest, 4'b0111);
    step;
    req_write[3] = 1'b0;
    step;
    // reset in the middle of a read
    req_address[0] = 32'h500; req_read[0] = 1'b1;
    step; step;
    reset = 1'b1;
    #1 chk("rst mid m1_read", m1_read, 1'b0);
    chk("rst mid waitreq", req_waitrequest, 4'hF);
    chk("rst mid m1_address", m1_address, 32'h0);
    req_read[0] = 1'b0;
    step; step;
    reset = 1'b0;
    step;
    m1_readdatavalid = 1'b1;
    #1 chk("stray rdv", req_readdatavalid, 4'h0);
    step;
    m1_readdatavalid = 1'b0;
    // round robin, everybody writing continuously from reset
    reset = 1'b1;
    step;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) req_address[i] = 32'h1000 + i;
    rr_on = 1'b1;
    req_write = 4'hF;
    repeat (10) step;
    req_write = 4'h0;
    rr_on = 1'b0;
    for (int i = 0; i < 5; i++) chk("rr order", (i < order.size()) ? order[i] : -1, exp_order[i]);
    step;
    // after reset, tiles 0 and 3 together: 0 then 3
    reset = 1'b1;
    step;
    reset = 1'b0;
    req_write[0] = 1'b1; req_write[3] = 1'b1;
    step;
    #1 chk("first after reset", m1_address, 32'h1000);
    step;
    req_write[0] = 1'b0;
    step;
    #1 chk("second after reset", m1_address, 32'h1003);
    step;
    req_write[3] = 1'b0;
    step;
    // interrupt aggregation and clear broadcast
    req_irq = 4'b0111;
    step; step;
    #1 chk("irq partial", irq, 1'b0);
    req_irq = 4'hF;
    #1 chk("irq lag", irq, 1'b0);
    step;
    #1 chk("irq set", irq, 1'b1);
    clear_interrupt = 1'b1;
    #1 chk("clear bcast", req_clear_interrupt, 4'hF);
    step;
    clear_interrupt = 1'b0;
    #1 chk("clear drop", req_clear_interrupt, 4'h0);
    req_irq = 4'b1110;
    #1 chk("irq hold", irq, 1'b1);
    step;
    #1 chk("irq drop", irq, 1'b0);
    step; step;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
